// File: rtl/crypto_pkg.sv
// ---------------------------------------------------------------------------
// crypto_pkg
//
// Shared definitions for the crypto round sequencer and anything that talks
// to it: default widths, the round count, the encrypt/decrypt select
// encodings and the sequencer state type.
// ---------------------------------------------------------------------------
package crypto_pkg;

   localparam int DATA_W     = 32;
   localparam int CNT_W      = 2;
   localparam int NUM_ROUNDS = 4;

   localparam logic ENC = 1'b0;
   localparam logic DEC = 1'b1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ROUND = 2'd1,
      DONE  = 2'd2
   } state_t;

endpackage

// File: rtl/crypto_round_sequencer.sv
// ---------------------------------------------------------------------------
// crypto_round_sequencer
//
// Sequential controller that sits in front of the combinational round
// datapath. It takes one operation from the CPU execute stage, then walks
// the datapath through every round. Each round's output is fed back in as
// the next round's data. The final word is handed back under a
// valid/ready handshake.
//
// Ports:
//   CLK          system clock, rising edge
//   RST          synchronous, active-high reset
//   in_valid     CPU presents a new operation
//   in_ready     sequencer can accept an operation this cycle
//   rs1          plaintext/ciphertext operand
//   rs2          user key
//   sel          0 = encrypt, 1 = decrypt
//   out_valid    result available on rd
//   out_ready    CPU consumes the result
//   rd           final result word
//   busy         operation in flight (used by the CPU to stall)
//   crypt_rs1    data word to the round datapath
//   crypt_rs2    latched key to the round datapath
//   crypt_count  round index to the round datapath
//   crypt_sel    latched encrypt/decrypt select to the round datapath
//   crypt_rd     round datapath output (combinational from crypt_*)
// ---------------------------------------------------------------------------
module crypto_round_sequencer #(
   parameter int DATA_W     = crypto_pkg::DATA_W,
   parameter int NUM_ROUNDS = crypto_pkg::NUM_ROUNDS,
   parameter int CNT_W      = crypto_pkg::CNT_W
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] rs1,
   input  logic [DATA_W-1:0] rs2,
   input  logic              sel,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] rd,
   output logic              busy,
   output logic [DATA_W-1:0] crypt_rs1,
   output logic [DATA_W-1:0] crypt_rs2,
   output logic [CNT_W-1:0]  crypt_count,
   output logic              crypt_sel,
   input  logic [DATA_W-1:0] crypt_rd
);

   import crypto_pkg::*;

   localparam logic [CNT_W-1:0] LAST_ENC_ROUND = CNT_W'(NUM_ROUNDS - 1);
   localparam logic [CNT_W-1:0] LAST_DEC_ROUND = '0;

   state_t              state_q;
   state_t              state_d;
   logic [DATA_W-1:0]   data_q;
   logic [DATA_W-1:0]   key_q;
   logic [DATA_W-1:0]   rd_q;
   logic                sel_q;
   logic [CNT_W-1:0]    round_q;
   logic                accept;
   logic                last_round;

   // Encryption counts up and finishes on the top index. Decryption runs
   // the same schedule backwards and finishes on index zero.
   assign last_round = (sel_q == ENC) ? (round_q == LAST_ENC_ROUND)
                                      : (round_q == LAST_DEC_ROUND);

   // Next-state and handshake decode. A new operation is taken either from
   // IDLE or from DONE in the same cycle the CPU drains the previous result.
   // This gives back-to-back operations with no idle bubble between them.
   always_comb begin
      state_d  = state_q;
      accept   = 1'b0;
      in_ready = 1'b0;
      case (state_q)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               accept  = 1'b1;
               state_d = ROUND;
            end
         end
         ROUND: begin
            if (last_round) begin
               state_d = DONE;
            end
         end
         DONE: begin
            in_ready = out_ready;
            if (out_ready) begin
               if (in_valid) begin
                  accept  = 1'b1;
                  state_d = ROUND;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State register. Reset drops any operation in flight straight back to
   // IDLE, so a partially computed result is never presented.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Operand, key and round-index registers. These feed the datapath
   // directly, so the datapath sees no combinational path from the CPU
   // inputs. Outside ROUND these registers just hold, which keeps crypt_*
   // stable. The result register is written only on the last round. This
   // keeps rd steady for as long as the CPU stalls the handshake.
   always_ff @(posedge CLK) begin
      if (RST) begin
         data_q  <= '0;
         key_q   <= '0;
         sel_q   <= 1'b0;
         round_q <= '0;
         rd_q    <= '0;
      end else if (accept) begin
         data_q  <= rs1;
         key_q   <= rs2;
         sel_q   <= sel;
         round_q <= (sel == ENC) ? LAST_DEC_ROUND : LAST_ENC_ROUND;
      end else if (state_q == ROUND) begin
         data_q <= crypt_rd;
         if (last_round) begin
            rd_q <= crypt_rd;
         end else if (sel_q == ENC) begin
            round_q <= round_q + CNT_W'(1);
         end else begin
            round_q <= round_q - CNT_W'(1);
         end
      end
   end

   // The datapath and CPU-facing outputs are plain register taps and
   // state decodes.
   assign crypt_rs1   = data_q;
   assign crypt_rs2   = key_q;
   assign crypt_sel   = sel_q;
   assign crypt_count = round_q;
   assign rd          = rd_q;
   assign out_valid   = (state_q == DONE);
   assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_crypto_round_sequencer.sv
// ---------------------------------------------------------------------------
// tb_crypto_round_sequencer
//
// Self-checking bench for crypto_round_sequencer. A stub round datapath
// computes crypt_rd = (crypt_rs1 ^ crypt_rs2) + crypt_count. A behavioural
// model derives each expected result by walking the round schedule with
// plain arithmetic.
// ---------------------------------------------------------------------------
module tb_crypto_round_sequencer;

   logic        CLK;
   logic        RST;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] rs1;
   logic [31:0] rs2;
   logic        sel;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] rd;
   logic        busy;
   logic [31:0] crypt_rs1;
   logic [31:0] crypt_rs2;
   logic [1:0]  crypt_count;
   logic        crypt_sel;
   logic [31:0] crypt_rd;

   int checks;
   int errors;

   logic [1:0]  cntSeq [24];
   logic [31:0] rs1Seq [24];
   logic        selSeq [24];
   int          latency;
   int          busyCycles;
   logic        busyAfter;
   logic        validSeen;
   logic [31:0] resultRd;

   crypto_round_sequencer dut (
      .CLK         (CLK),
      .RST         (RST),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .rs1         (rs1),
      .rs2         (rs2),
      .sel         (sel),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .rd          (rd),
      .busy        (busy),
      .crypt_rs1   (crypt_rs1),
      .crypt_rs2   (crypt_rs2),
      .crypt_count (crypt_count),
      .crypt_sel   (crypt_sel),
      .crypt_rd    (crypt_rd)
   );

   // Stand-in for the combinational round datapath.
   assign crypt_rd = (crypt_rs1 ^ crypt_rs2) + 32'(crypt_count);

   // Free-running 100 MHz clock.
   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   // Hard stop in case something hangs outside the bounded waits.
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation time limit reached, got timeout expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // Reference result: apply every round in schedule order. Encrypt uses
   // indices 0..3 and decrypt uses 3..0.
   function automatic logic [31:0] refModel(input logic [31:0] a, input logic [31:0] k,
                                            input logic s);
      logic [31:0] d;
      int          idx;
      d = a;
      for (int r = 0; r < 4; r++) begin
         idx = s ? (3 - r) : r;
         d   = (d ^ k) + 32'(idx);
      end
      return d;
   endfunction

   // Runs one full operation with out_ready held high. Records the
   // per-round datapath inputs, the latency, the busy cycles and the result.
   task automatic applyStimulus(input logic [31:0] a, input logic [31:0] k, input logic s);
      int nObs;
      rs1       = a;
      rs2       = k;
      sel       = s;
      in_valid  = 1'b1;
      out_ready = 1'b1;
      @(posedge CLK); #1;
      in_valid   = 1'b0;
      latency    = 0;
      busyCycles = 0;
      nObs       = 0;
      while (!out_valid && latency < 20) begin
         cntSeq[nObs] = crypt_count;
         rs1Seq[nObs] = crypt_rs1;
         selSeq[nObs] = crypt_sel;
         if (busy) busyCycles++;
         nObs++;
         @(posedge CLK); #1;
         latency++;
      end
      validSeen = out_valid;
      resultRd  = rd;
      if (busy) busyCycles++;
      @(posedge CLK); #1;
      busyAfter = busy;
   endtask

   task automatic test_reset();
      RST       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      rs1       = 32'hDEADBEEF;
      rs2       = 32'hCAFEF00D;
      sel       = 1'b1;
      @(posedge CLK); #1;
      @(posedge CLK); #1;
      RST = 1'b0;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
         errors++; $display("[TB] FAIL reset_in_ready: got %b expected 1", in_ready);
      end
      checks++;
      if (out_valid !== 1'b0 || busy !== 1'b0) begin
         errors++; $display("[TB] FAIL reset_flags: got out_valid=%b busy=%b expected 0/0", out_valid, busy);
      end
      checks++;
      if (rd !== 32'h0) begin
         errors++; $display("[TB] FAIL reset_rd: got %h expected 00000000", rd);
      end
      checks++;
      if (crypt_rs1 !== 32'h0 || crypt_rs2 !== 32'h0 || crypt_count !== 2'd0 || crypt_sel !== 1'b0) begin
         errors++; $display("[TB] FAIL reset_crypt: got rs1=%h rs2=%h cnt=%0d sel=%b expected all zero",
                            crypt_rs1, crypt_rs2, crypt_count, crypt_sel);
      end
   endtask

   task automatic test_encrypt_zero();
      applyStimulus(32'h0, 32'h0, 1'b0);
      checks++;
      if (latency !== 4 || validSeen !== 1'b1) begin
         errors++; $display("[TB] FAIL enc_zero_latency: got %0d (valid=%b) expected 4", latency, validSeen);
      end
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (32'(cntSeq[i]) !== 32'(i)) begin
            errors++; $display("[TB] FAIL enc_zero_count[%0d]: got %0d expected %0d", i, cntSeq[i], i);
         end
      end
      checks++;
      if (resultRd !== 32'h00000006) begin
         errors++; $display("[TB] FAIL enc_zero_rd: got %h expected 00000006", resultRd);
      end
      checks++;
      if (busyCycles !== 5 || busyAfter !== 1'b0) begin
         errors++; $display("[TB] FAIL enc_zero_busy: got %0d cycles (after=%b) expected 5 (after=0)",
                            busyCycles, busyAfter);
      end
   endtask

   task automatic test_encrypt_wrap();
      logic [31:0] expData [4];
      expData[0] = 32'h00000000;
      expData[1] = 32'hFFFFFFFF;
      expData[2] = 32'h00000001;
      expData[3] = 32'h00000000;
      applyStimulus(32'h0, 32'hFFFFFFFF, 1'b0);
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (rs1Seq[i] !== expData[i]) begin
            errors++; $display("[TB] FAIL enc_wrap_data[%0d]: got %h expected %h", i, rs1Seq[i], expData[i]);
         end
      end
      checks++;
      if (resultRd !== 32'h00000002) begin
         errors++; $display("[TB] FAIL enc_wrap_rd: got %h expected 00000002", resultRd);
      end
   endtask

   task automatic test_decrypt();
      applyStimulus(32'h0, 32'h0, 1'b1);
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (32'(cntSeq[i]) !== 32'(3 - i) || selSeq[i] !== 1'b1) begin
            errors++; $display("[TB] FAIL dec_round[%0d]: got cnt=%0d sel=%b expected cnt=%0d sel=1",
                               i, cntSeq[i], selSeq[i], 3 - i);
         end
      end
      checks++;
      if (resultRd !== 32'h00000006) begin
         errors++; $display("[TB] FAIL dec_rd: got %h expected 00000006", resultRd);
      end
   endtask

   task automatic test_hold();
      logic [31:0] a, k, b, kb;
      logic        s, sb;
      logic [31:0] held;
      int          cyc;
      a  = $urandom; k  = $urandom; s  = 1'($urandom_range(0, 1));
      b  = $urandom; kb = $urandom; sb = 1'($urandom_range(0, 1));
      rs1 = a; rs2 = k; sel = s; in_valid = 1'b1; out_ready = 1'b0;
      @(posedge CLK); #1;
      in_valid = 1'b0;
      cyc = 0;
      while (!out_valid && cyc < 20) begin
         @(posedge CLK); #1;
         cyc++;
      end
      checks++;
      if (cyc !== 4) begin
         errors++; $display("[TB] FAIL hold_latency: got %0d expected 4", cyc);
      end
      held = rd;
      checks++;
      if (held !== refModel(a, k, s)) begin
         errors++; $display("[TB] FAIL hold_result: got %h expected %h", held, refModel(a, k, s));
      end
      for (int i = 0; i < 10; i++) begin
         @(posedge CLK); #1;
         checks++;
         if (out_valid !== 1'b1 || rd !== held || in_ready !== 1'b0) begin
            errors++; $display("[TB] FAIL hold_stall[%0d]: got valid=%b rd=%h in_ready=%b expected 1/%h/0",
                               i, out_valid, rd, in_ready, held);
         end
      end
      rs1 = b; rs2 = kb; sel = sb; in_valid = 1'b1; out_ready = 1'b1;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
         errors++; $display("[TB] FAIL hold_release_ready: got %b expected 1", in_ready);
      end
      @(posedge CLK); #1;
      in_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b0 || busy !== 1'b1 || crypt_rs1 !== b || crypt_rs2 !== kb) begin
         errors++; $display("[TB] FAIL hold_b2b_accept: got valid=%b busy=%b rs1=%h rs2=%h expected 0/1/%h/%h",
                            out_valid, busy, crypt_rs1, crypt_rs2, b, kb);
      end
      cyc = 0;
      while (!out_valid && cyc < 20) begin
         @(posedge CLK); #1;
         cyc++;
      end
      checks++;
      if (rd !== refModel(b, kb, sb) || cyc !== 4) begin
         errors++; $display("[TB] FAIL hold_next_result: got %h after %0d expected %h after 4",
                            rd, cyc, refModel(b, kb, sb));
      end
      @(posedge CLK); #1;
   endtask

   task automatic test_ignore_in_valid();
      logic [31:0] a, k;
      logic        s;
      int          cyc;
      a = $urandom; k = $urandom; s = 1'($urandom_range(0, 1));
      rs1 = a; rs2 = k; sel = s; in_valid = 1'b1; out_ready = 1'b1;
      @(posedge CLK); #1;
      in_valid = 1'b0;
      @(posedge CLK); #1;
      rs1 = ~a; rs2 = k ^ 32'h5A5A5A5A; sel = ~s; in_valid = 1'b1;
      #1;
      checks++;
      if (in_ready !== 1'b0) begin
         errors++; $display("[TB] FAIL ignore_in_ready: got %b expected 0", in_ready);
      end
      @(posedge CLK); #1;
      in_valid = 1'b0;
      checks++;
      if (crypt_rs2 !== k || crypt_sel !== s) begin
         errors++; $display("[TB] FAIL ignore_latched: got key=%h sel=%b expected %h/%b", crypt_rs2, crypt_sel, k, s);
      end
      cyc = 0;
      while (!out_valid && cyc < 20) begin
         @(posedge CLK); #1;
         cyc++;
      end
      checks++;
      if (rd !== refModel(a, k, s)) begin
         errors++; $display("[TB] FAIL ignore_result: got %h expected %h", rd, refModel(a, k, s));
      end
      @(posedge CLK); #1;
   endtask

   task automatic test_reset_abort();
      logic [31:0] a, k;
      logic        s;
      a = $urandom; k = $urandom; s = 1'($urandom_range(0, 1));
      rs1 = a; rs2 = k; sel = s; in_valid = 1'b1; out_ready = 1'b1;
      @(posedge CLK); #1;
      in_valid = 1'b0;
      @(posedge CLK); #1;
      @(posedge CLK); #1;
      RST = 1'b1;
      @(posedge CLK); #1;
      RST = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b0 || busy !== 1'b0 || rd !== 32'h0 || in_ready !== 1'b1) begin
         errors++; $display("[TB] FAIL abort_state: got valid=%b busy=%b rd=%h in_ready=%b expected 0/0/0/1",
                            out_valid, busy, rd, in_ready);
      end
      @(posedge CLK); #1;
      checks++;
      if (out_valid !== 1'b0 || busy !== 1'b0) begin
         errors++; $display("[TB] FAIL abort_stays_idle: got valid=%b busy=%b expected 0/0", out_valid, busy);
      end
      a = $urandom; k = $urandom; s = 1'($urandom_range(0, 1));
      applyStimulus(a, k, s);
      checks++;
      if (resultRd !== refModel(a, k, s) || latency !== 4) begin
         errors++; $display("[TB] FAIL abort_recover: got %h after %0d expected %h after 4",
                            resultRd, latency, refModel(a, k, s));
      end
   endtask

   task automatic test_random();
      logic [31:0] a, k;
      logic        s;
      for (int n = 0; n < 12; n++) begin
         a = $urandom; k = $urandom; s = 1'($urandom_range(0, 1));
         applyStimulus(a, k, s);
         checks++;
         if (resultRd !== refModel(a, k, s)) begin
            errors++; $display("[TB] FAIL rand_rd[%0d]: got %h expected %h", n, resultRd, refModel(a, k, s));
         end
         checks++;
         if (latency !== 4 || 32'(cntSeq[0]) !== (s ? 32'd3 : 32'd0)) begin
            errors++; $display("[TB] FAIL rand_sched[%0d]: got lat=%0d first=%0d expected 4/%0d",
                               n, latency, cntSeq[0], s ? 3 : 0);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] a [6];
      logic [31:0] k [6];
      logic        s [6];
      int          cyc;
      for (int i = 0; i < 6; i++) begin
         a[i] = $urandom; k[i] = $urandom; s[i] = 1'($urandom_range(0, 1));
      end
      rs1 = a[0]; rs2 = k[0]; sel = s[0]; in_valid = 1'b1; out_ready = 1'b1;
      @(posedge CLK); #1;
      for (int i = 0; i < 6; i++) begin
         if (i < 5) begin
            rs1 = a[i+1]; rs2 = k[i+1]; sel = s[i+1]; in_valid = 1'b1;
         end else begin
            in_valid = 1'b0;
         end
         cyc = 0;
         while (!out_valid && cyc < 20) begin
            @(posedge CLK); #1;
            cyc++;
         end
         checks++;
         if (cyc !== 4) begin
            errors++; $display("[TB] FAIL b2b_spacing[%0d]: got %0d expected 4", i, cyc);
         end
         checks++;
         if (rd !== refModel(a[i], k[i], s[i])) begin
            errors++; $display("[TB] FAIL b2b_rd[%0d]: got %h expected %h", i, rd, refModel(a[i], k[i], s[i]));
         end
         @(posedge CLK); #1;
      end
      checks++;
      if (busy !== 1'b0) begin
         errors++; $display("[TB] FAIL b2b_idle: got busy=%b expected 0", busy);
      end
   endtask

   // Scenario sequence; each task leaves the DUT idle for the next.
   initial begin
      checks    = 0;
      errors    = 0;
      RST       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      rs1       = '0;
      rs2       = '0;
      sel       = 1'b0;
      $display("[TB] starting crypto_round_sequencer bench");
      test_reset();
      test_encrypt_zero();
      test_encrypt_wrap();
      test_decrypt();
      test_hold();
      test_ignore_in_valid();
      test_reset_abort();
      test_random();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/crypto_round_sequencer.md
Name: crypto_round_sequencer

Overview:
- Sequential controller placed directly upstream of the combinational CryptographyModule round datapath.
- Accepts a 32-bit operand (rs1), a 32-bit user key (rs2) and an encrypt/decrypt select from the CPU execute stage.
- Drives the round datapath through all rounds, feeding each round's rd back in as the next round's data.
- Presents the final word to the CPU under a valid/ready handshake. Provides busy for pipeline stall.

Parameters:
DATA_W, 32, operand/key/result width
NUM_ROUNDS, 4, rounds per operation; must be ≤ 2**CNT_W
CNT_W, 2, width of round counter driven to datapath

Ports:
CLK  input  1  system clock, rising edge
RST  input  1  synchronous, active-high reset
in_valid  input  1  CPU presents new operation
in_ready  output  1  sequencer can accept operation this cycle
rs1  input  DATA_W  plaintext/ciphertext operand
rs2  input  DATA_W  user key
sel  input  1  0 = encrypt, 1 = decrypt
out_valid  output  1  result available
out_ready  input  1  CPU consumes result
rd  output  DATA_W  final result
busy  output  1  operation in flight (state ≠ IDLE)
crypt_rs1  output  DATA_W  data word to round datapath
crypt_rs2  output  DATA_W  latched key to round datapath
crypt_count  output  CNT_W  round index to datapath
crypt_sel  output  1  latched sel to datapath
crypt_rd  input  DATA_W  round datapath output (combinational from crypt_* outputs)

Behaviour:
- One clock domain (CLK). RST is synchronous and active-high: on a CLK edge with RST=1, all registers clear.
- Reset state: IDLE; data_q=0, key_q=0, sel_q=0, round_q=0, rd=0, out_valid=0, busy=0, in_ready=1.
- FSM states are IDLE, ROUND and DONE.
- IDLE:
  - in_ready=1.
  - When in_valid=1: data_q←rs1, key_q←rs2, sel_q←sel.
  - round_q←0 when sel=0, else NUM_ROUNDS-1. Next state is ROUND.
- ROUND:
  - Outputs: crypt_rs1=data_q, crypt_rs2=key_q, crypt_sel=sel_q, crypt_count=round_q. crypt_* are direct register outputs with no combinational paths from inputs.
  - Each edge: data_q←crypt_rd.
  - Encrypt: round_q increments. Decrypt: round_q decrements.
  - Last round (round_q==NUM_ROUNDS-1 for encrypt, round_q==0 for decrypt): data_q←crypt_rd and go to DONE. round_q does not wrap.
  - in_ready=0. in_valid is ignored and the operands are not sampled.
- DONE:
  - out_valid=1 and rd=data_q. rd is stable while out_valid=1 and out_ready=0.
  - out_ready=1 with in_valid=0: go to IDLE.
  - out_ready=1 with in_valid=1: back-to-back accept. Load the new operands as in IDLE and go to ROUND. in_ready=out_ready in DONE.
  - out_ready=0: hold indefinitely.
- Latency: accept edge E0; round edges E1..E_NUM_ROUNDS. out_valid rises after E4 (4 cycles after accept, default). Throughput is one operation per 5 cycles with back-to-back accept.
- busy=1 in ROUND and DONE.
- The crypt_* outputs keep their last values outside ROUND. The datapath output is ignored outside ROUND.
- RST asserted in any state, mid-round included, aborts the operation: IDLE next cycle, out_valid=0, no partial result emitted.
- Arithmetic: round_q is CNT_W-bit unsigned. Data is passed through unmodified; the sequencer performs no data arithmetic.

Decomposition:
- Shared package crypto_pkg holds:
  - state enum {IDLE, ROUND, DONE}
  - DATA_W and CNT_W constants
  - ENC=1'b0 and DEC=1'b1
- No sub-module; single FSM plus registers.
- A top-level wrapper instantiates crypto_round_sequencer with CryptographyModule.

Test Plan:
The bench stub for the datapath is crypt_rd = (crypt_rs1 ^ crypt_rs2) + crypt_count.
- Encrypt, rs1=0, rs2=0, sel=0, out_ready=1 → crypt_count sequence 0,1,2,3; out_valid exactly 4 cycles after accept; rd=0x00000006; busy high for 5 cycles.
- Encrypt, rs1=0, rs2=0xFFFFFFFF → intermediate data 0xFFFFFFFF, 0x00000001, 0x00000000 (wrap); final rd=0x00000002.
- Decrypt, rs1=0, rs2=0, sel=1 → crypt_count 3,2,1,0; crypt_sel=1 throughout; rd=0x00000006.
- out_ready held 0 for 10 cycles after completion → out_valid stays 1, rd stable, in_ready=0. Then out_ready=1 with in_valid=1 carrying a new op → accepted the same edge and the next result is correct.
- in_valid pulsed with different rs1 during ROUND → ignored; result unchanged.
- RST asserted in round 2 → next cycle state IDLE, out_valid=0, rd=0. A new op afterwards completes normally.
